// File: rtl/mem_bus_initiator_if.sv
// Core-request / MMU-port bundle for mem_bus_initiator.
// master: the initiator block itself; slave: the core/MMU side (testbench or wrapper).
interface mem_bus_initiator_if;

  // Core request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;

  // Core response channel
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // MMU port
  logic [15:0] addressCPU;
  logic [31:0] dataCPU;
  logic        wrenCPU;
  logic [31:0] qCPU;
  logic        stallCPU;

  // Status
  logic        busy;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, qCPU, stallCPU,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, addressCPU, dataCPU, wrenCPU, busy
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, qCPU, stallCPU,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, addressCPU, dataCPU, wrenCPU, busy
  );

endinterface

// File: rtl/mem_bus_initiator.sv
// Bus initiator between the core execute stage and the MMU.
// Takes one load/store per valid/ready handshake, drives it onto the MMU port, honours
// stallCPU (with a timeout abort), absorbs the RAM read latency and returns one response.
// Every output is a flop.
module mem_bus_initiator #(
  parameter int unsigned RD_LAT    = 1,   // legal 1..3
  parameter int unsigned STALL_MAX = 255  // legal 1..65535
) (
  input logic                 clk,
  input logic                 nRst,
  mem_bus_initiator_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRd
  } state_e;

  // Stall count value at which one more stalled edge reaches STALL_MAX.
  localparam logic [15:0] StallLast = 16'(STALL_MAX - 1);
  localparam logic [1:0]  RdLatInit = 2'(RD_LAT);

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wren_q, wren_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_d      = wren_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_addr;
          data_d      = bus.req_wdata;
          wren_d      = bus.req_wr;
          stall_cnt_d = '0;
          state_d     = StIssue;
        end
      end

      StIssue: begin
        if (bus.stallCPU) begin
          if (stall_cnt_q == StallLast) begin
            // Hung peripheral: drop the request and report an error response.
            wren_d      = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = StIdle;
          end else begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end else if (wren_q) begin
          // wren_q doubles as the store flag while in ISSUE.
          wren_d      = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          lat_cnt_d = RdLatInit;
          state_d   = StWaitRd;
        end
      end

      StWaitRd: begin
        // The MMU has already taken the address, so stallCPU no longer matters here.
        if (lat_cnt_q == 2'd1) begin
          rdata_d     = bus.qCPU;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end

      default: begin
        wren_d  = 1'b0;
        state_d = StIdle;
      end
    endcase

    // Ready during the response cycle so a new request can be taken back-to-back.
    req_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  // State and output registers; reset aborts any request in flight without a response.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= StIdle;
      stall_cnt_q <= '0;
      lat_cnt_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Drive the interface straight from the flops.
  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.addressCPU = addr_q;
  assign bus.dataCPU    = data_q;
  assign bus.wrenCPU    = wren_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator (RD_LAT=1, STALL_MAX=4) with a 1-cycle RAM model.
module tb_mem_bus_initiator;

  logic clk;
  logic nRst;
  int   n_cmp;
  int   n_err;
  int   rsp_cnt;
  int   idx;
  logic acc;

  logic [31:0] mem [0:65535];
  logic [15:0] b_addr [3];
  logic [31:0] b_data [3];
  logic        b_wr   [3];

  mem_bus_initiator_if bus ();

  mem_bus_initiator #(
    .RD_LAT    (1),
    .STALL_MAX (4)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: registered read data, write on wrenCPU.
  always @(posedge clk) begin
    if (bus.wrenCPU) mem[bus.addressCPU] <= bus.dataCPU;
    bus.qCPU <= mem[bus.addressCPU];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.stallCPU  = 1'b0;
    b_addr[0] = 16'h0030; b_data[0] = 32'hCAFEF00D; b_wr[0] = 1'b1;
    b_addr[1] = 16'h0030; b_data[1] = 32'h00000000; b_wr[1] = 1'b0;
    b_addr[2] = 16'h0031; b_data[2] = 32'h0BADF00D; b_wr[2] = 1'b1;

    // Reset values
    nRst = 1'b1;
    #1 nRst = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
    check("rst_address",   32'(bus.addressCPU), 32'd0);
    check("rst_data",      bus.dataCPU,        32'd0);
    check("rst_wren",      32'(bus.wrenCPU),   32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    nRst = 1'b1;
    tick();

    // Store, no stall: wren for exactly one cycle, ack at E1
    present(1'b1, 16'h0010, 32'hDEADBEEF);
    tick();  // E0
    bus.req_valid = 1'b0;
    check("st_wren_e0",  32'(bus.wrenCPU),    32'd1);
    check("st_addr_e0",  32'(bus.addressCPU), 32'h0010);
    check("st_data_e0",  bus.dataCPU,         32'hDEADBEEF);
    check("st_ready_e0", 32'(bus.req_ready),  32'd0);
    check("st_busy_e0",  32'(bus.busy),       32'd1);
    check("st_rsp_e0",   32'(bus.rsp_valid),  32'd0);
    tick();  // E1
    check("st_rsp_e1",   32'(bus.rsp_valid),  32'd1);
    check("st_err_e1",   32'(bus.rsp_err),    32'd0);
    check("st_wren_e1",  32'(bus.wrenCPU),    32'd0);
    check("st_ready_e1", 32'(bus.req_ready),  32'd1);
    check("st_mem",      mem[16'h0010],       32'hDEADBEEF);
    tick();
    check("st_rsp_e2",   32'(bus.rsp_valid),  32'd0);

    // Load from RAM preloaded with 0x12345678: response at E0+2
    mem[16'h0010] = 32'h12345678;
    present(1'b0, 16'h0010, 32'h0);
    tick();  // E0
    bus.req_valid = 1'b0;
    check("ld_wren_e0",  32'(bus.wrenCPU),   32'd0);
    check("ld_busy_e0",  32'(bus.busy),      32'd1);
    tick();  // E1
    check("ld_rsp_e1",   32'(bus.rsp_valid), 32'd0);
    check("ld_wren_e1",  32'(bus.wrenCPU),   32'd0);
    tick();  // E2
    check("ld_rsp_e2",   32'(bus.rsp_valid), 32'd1);
    check("ld_rdata_e2", bus.rsp_rdata,      32'h12345678);
    check("ld_err_e2",   32'(bus.rsp_err),   32'd0);
    tick();
    check("ld_rsp_e3",   32'(bus.rsp_valid), 32'd0);

    // Store stalled for 3 cycles: bus held 4 cycles, single ack after stall drops
    present(1'b1, 16'hFFFF, 32'h0000ABCD);
    bus.stallCPU = 1'b1;
    tick();  // E0
    bus.req_valid = 1'b0;
    check("sst_wren_e0", 32'(bus.wrenCPU), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("sst_wren_e%0d", i), 32'(bus.wrenCPU),    32'd1);
      check($sformatf("sst_addr_e%0d", i), 32'(bus.addressCPU), 32'hFFFF);
      check($sformatf("sst_data_e%0d", i), bus.dataCPU,         32'h0000ABCD);
      check($sformatf("sst_rsp_e%0d", i),  32'(bus.rsp_valid),  32'd0);
    end
    bus.stallCPU = 1'b0;
    tick();  // E4
    check("sst_rsp_e4",   32'(bus.rsp_valid), 32'd1);
    check("sst_err_e4",   32'(bus.rsp_err),   32'd0);
    check("sst_wren_e4",  32'(bus.wrenCPU),   32'd0);
    check("sst_rdata_e4", bus.rsp_rdata,      32'h12345678);
    tick();
    check("sst_rsp_e5",   32'(bus.rsp_valid), 32'd0);

    // Stall timeout with STALL_MAX=4: abort at the 4th stalled edge
    present(1'b1, 16'h0020, 32'h00000055);
    bus.stallCPU = 1'b1;
    tick();  // E0
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("to_rsp_e%0d", i),  32'(bus.rsp_valid), 32'd0);
      check($sformatf("to_wren_e%0d", i), 32'(bus.wrenCPU),   32'd1);
    end
    tick();  // E4
    check("to_rsp_e4",   32'(bus.rsp_valid), 32'd1);
    check("to_err_e4",   32'(bus.rsp_err),   32'd1);
    check("to_wren_e4",  32'(bus.wrenCPU),   32'd0);
    check("to_rdata_e4", bus.rsp_rdata,      32'h12345678);
    check("to_busy_e4",  32'(bus.busy),      32'd0);
    check("to_ready_e4", 32'(bus.req_ready), 32'd1);
    bus.stallCPU = 1'b0;
    tick();
    check("to_rsp_e5",   32'(bus.rsp_valid), 32'd0);
    check("to_err_e5",   32'(bus.rsp_err),   32'd0);

    // req_valid held high: store / load / store, each taken only when ready
    idx     = 0;
    rsp_cnt = 0;
    present(b_wr[0], b_addr[0], b_data[0]);
    for (int cyc = 0; cyc < 20 && (rsp_cnt < 3 || idx < 3); cyc++) begin
      acc = bus.req_ready && bus.req_valid;
      tick();
      if (bus.rsp_valid) begin
        check($sformatf("b2b_err_%0d", rsp_cnt), 32'(bus.rsp_err), 32'd0);
        if (rsp_cnt == 1) check("b2b_ld_rdata", bus.rsp_rdata, 32'hCAFEF00D);
        rsp_cnt++;
      end
      if (acc) begin
        check($sformatf("b2b_addr_%0d", idx), 32'(bus.addressCPU), 32'(b_addr[idx]));
        check($sformatf("b2b_wren_%0d", idx), 32'(bus.wrenCPU),    32'(b_wr[idx]));
        check($sformatf("b2b_rsps_at_acc_%0d", idx), 32'(rsp_cnt), 32'(idx));
        idx++;
        if (idx < 3) present(b_wr[idx], b_addr[idx], b_data[idx]);
        else bus.req_valid = 1'b0;
      end
    end
    check("b2b_accepts",   32'(idx),     32'd3);
    check("b2b_rsp_count", 32'(rsp_cnt), 32'd3);
    tick();
    check("b2b_rsp_idle",  32'(bus.rsp_valid), 32'd0);

    // Reset during a stalled store: wren drops at once, no response
    present(1'b1, 16'h0040, 32'h00000077);
    bus.stallCPU = 1'b1;
    tick();  // E0
    bus.req_valid = 1'b0;
    tick();  // E1, stalled
    check("rr_wren_before", 32'(bus.wrenCPU), 32'd1);
    nRst = 1'b0;
    #1;
    check("rr_wren_async",  32'(bus.wrenCPU),   32'd0);
    check("rr_busy_async",  32'(bus.busy),      32'd0);
    check("rr_ready_async", 32'(bus.req_ready), 32'd1);
    bus.stallCPU = 1'b0;
    tick();
    check("rr_rsp_in_rst",  32'(bus.rsp_valid), 32'd0);
    nRst = 1'b1;
    tick();
    check("rr_rsp_after",   32'(bus.rsp_valid), 32'd0);
    check("rr_ready_after", 32'(bus.req_ready), 32'd1);
    check("rr_rdata_after", bus.rsp_rdata,      32'd0);
    present(1'b1, 16'h0041, 32'h00000099);
    tick();  // E0
    bus.req_valid = 1'b0;
    check("rr_next_wren", 32'(bus.wrenCPU),    32'd1);
    check("rr_next_addr", 32'(bus.addressCPU), 32'h0041);
    tick();  // E1
    check("rr_next_rsp",  32'(bus.rsp_valid),  32'd1);
    check("rr_next_err",  32'(bus.rsp_err),    32'd0);
    check("rr_next_mem",  mem[16'h0041],       32'h00000099);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
